// File: rtl/pe_column_sequencer_if.sv
// ---------------------------------------------------------------------------
// pe_column_sequencer_if
//   Bundles the job, load, PE-column and result signals of one PE column
//   sequencer.
//   master : the sequencer (drives the PE column and the result port)
//   slave  : dispatcher / PE column / result consumer side
//
//   job_valid/job_ready/job_len         job request handshake
//   ld_valid/ld_ready/ld_kernel/ld_neuron  load beats from the global buffer
//   controlSignal/kernelOut/neuronOut   column-wide PE drive
//   colAdderIn/colAdderOut              top PE adder input, bottom PE output
//   res_valid/res_ready/res_data        accumulated column result
// ---------------------------------------------------------------------------
interface pe_column_sequencer_if #(
    parameter int W      = 16,
    parameter int A      = 7,
    parameter int CTR_IP = 8
);
    logic              job_valid;
    logic              job_ready;
    logic [A:0]        job_len;
    logic              ld_valid;
    logic              ld_ready;
    logic [W-1:0]      ld_kernel;
    logic [W-1:0]      ld_neuron;
    logic [CTR_IP-1:0] controlSignal;
    logic [W-1:0]      kernelOut;
    logic [W-1:0]      neuronOut;
    logic [W-1:0]      colAdderIn;
    logic [W-1:0]      colAdderOut;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_data;

    modport master (
        input  job_valid, job_len, ld_valid, ld_kernel, ld_neuron,
               colAdderOut, res_ready,
        output job_ready, ld_ready, controlSignal, kernelOut, neuronOut,
               colAdderIn, res_valid, res_data
    );

    modport slave (
        output job_valid, job_len, ld_valid, ld_kernel, ld_neuron,
               colAdderOut, res_ready,
        input  job_ready, ld_ready, controlSignal, kernelOut, neuronOut,
               colAdderIn, res_valid, res_data
    );
endinterface

// File: rtl/pe_column_sequencer.sv
// ---------------------------------------------------------------------------
// pe_column_sequencer
//   Initiator side of one PE column. Accepts a job of L MAC steps, streams L
//   kernel/neuron pairs into the PE local stores, rewinds the PE pointers,
//   issues L compute cycles and accumulates the column's bottom adder output
//   RD_LAT cycles after each compute cycle. The sum is returned on a
//   valid/ready result port.
//
//   Ports:
//     CLK    clock
//     RST_N  synchronous active-low reset
//     bus    pe_column_sequencer_if.master (job, load, PE column, result)
//
//   controlSignal[1:0]: 00 IDLE, 01 CLR, 10 LOAD, 11 COMPUTE; upper bits 0.
//
//   Build option:
//     PE_SEQ_SAT_EN  defined   -> signed saturating accumulation, sticky
//                                 until the job ends
//                    undefined -> modulo 2^W wrap accumulation
// ---------------------------------------------------------------------------
module pe_column_sequencer #(
    parameter int W      = 16,
    parameter int A      = 7,
    parameter int CTR_IP = 8,
    parameter int RD_LAT = 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    pe_column_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_CLR2,
        S_COMPUTE,
        S_DRAIN,
        S_OUTPUT
    } state_t;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_COMP = 2'b11;

    state_t              r_state;
    state_t              w_next;
    logic [A:0]          r_len;
    logic [A:0]          r_cnt;
    logic [A:0]          w_cnt_inc;
    logic                w_cnt_en;
    logic [RD_LAT-1:0]   r_vld_sr;
    logic                w_sample;
    logic signed [W-1:0] r_acc;

    logic [1:0]          w_op;
    logic [W-1:0]        w_kernel;
    logic [W-1:0]        w_neuron;
    logic                w_job_ready;
    logic                w_ld_ready;
    logic                w_res_valid;

`ifdef PE_SEQ_SAT_EN
    logic                r_sat;

    function automatic logic signed [W-1:0] sat_add(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b
    );
        logic signed [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1])
            return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return s[W-1:0];
    endfunction

    function automatic logic sat_ovf(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b
    );
        logic signed [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        return s[W] != s[W-1];
    endfunction
`else
    function automatic logic signed [W-1:0] wrap_add(
        input logic signed [W-1:0] a,
        input logic signed [W-1:0] b
    );
        return a + b;
    endfunction
`endif

    assign w_cnt_inc = r_cnt + (A+1)'(1);
    // The MSB of the valid shift register lines up with the adder output of
    // the compute cycle issued RD_LAT cycles earlier.
    assign w_sample  = r_vld_sr[RD_LAT-1];

    // Next-state and column drive
    always_comb begin
        w_next      = r_state;
        w_op        = OP_IDLE;
        w_kernel    = '0;
        w_neuron    = '0;
        w_job_ready = 1'b0;
        w_ld_ready  = 1'b0;
        w_res_valid = 1'b0;
        w_cnt_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_job_ready = 1'b1;
                if (bus.job_valid)
                    w_next = S_CLR;
            end
            S_CLR: begin
                w_op   = OP_CLR;
                w_next = (r_len == '0) ? S_OUTPUT : S_LOAD;
            end
            S_LOAD: begin
                w_ld_ready = 1'b1;
                if (bus.ld_valid) begin
                    w_op     = OP_LOAD;
                    w_kernel = bus.ld_kernel;
                    w_neuron = bus.ld_neuron;
                    w_cnt_en = 1'b1;
                    if (w_cnt_inc == r_len)
                        w_next = S_CLR2;
                end
            end
            S_CLR2: begin
                w_op   = OP_CLR;
                w_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                w_op     = OP_COMP;
                w_cnt_en = 1'b1;
                if (w_cnt_inc == r_len)
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_cnt_en = 1'b1;
                if (r_cnt == (A+1)'(RD_LAT - 1))
                    w_next = S_OUTPUT;
            end
            S_OUTPUT: begin
                w_res_valid = 1'b1;
                if (bus.res_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State, counters, sample pipeline and accumulator
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_cnt    <= '0;
            r_vld_sr <= '0;
            r_acc    <= '0;
`ifdef PE_SEQ_SAT_EN
            r_sat    <= 1'b0;
`endif
        end else begin
            r_state  <= w_next;
            r_vld_sr <= (r_vld_sr << 1) | RD_LAT'(r_state == S_COMPUTE);

            // One counter serves load beats, compute cycles and drain cycles;
            // it restarts on every state change.
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_cnt_en)
                r_cnt <= w_cnt_inc;

            if (r_state == S_IDLE && bus.job_valid) begin
                r_len <= bus.job_len;
                r_acc <= '0;
`ifdef PE_SEQ_SAT_EN
                r_sat <= 1'b0;
`endif
            end else if (w_sample) begin
`ifdef PE_SEQ_SAT_EN
                // Once clamped, the accumulator holds for the rest of the job.
                if (!r_sat) begin
                    r_acc <= sat_add(r_acc, $signed(bus.colAdderOut));
                    r_sat <= sat_ovf(r_acc, $signed(bus.colAdderOut));
                end
`else
                r_acc <= wrap_add(r_acc, $signed(bus.colAdderOut));
`endif
            end
        end
    end

    assign bus.controlSignal = CTR_IP'(w_op);
    assign bus.kernelOut     = w_kernel;
    assign bus.neuronOut     = w_neuron;
    assign bus.colAdderIn    = '0;
    assign bus.job_ready     = w_job_ready;
    assign bus.ld_ready      = w_ld_ready;
    assign bus.res_valid     = w_res_valid;
    assign bus.res_data      = r_acc;

endmodule

// File: tb/tb_pe_column_sequencer.sv
module tb_pe_column_sequencer;

    localparam int W      = 16;
    localparam int A      = 7;
    localparam int CTR_IP = 8;
    localparam int RD_LAT = 1;
    localparam int AW     = CTR_IP + 3*W + 3;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_COMP = 2'b11;

    // data modes
    localparam int D_RAND = 0;
    localparam int D_FIX  = 1;
    localparam int D_SAT  = 2;
    // beat patterns
    localparam int P_CONT   = 0;
    localparam int P_TOGGLE = 1;
    localparam int P_RAND   = 2;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] k;
        logic [W-1:0] n;
        logic         jr;
        logic         lr;
        logic         rv;
        logic         z;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    pe_column_sequencer_if #(.W(W), .A(A), .CTR_IP(CTR_IP)) bus ();

    pe_column_sequencer #(.W(W), .A(A), .CTR_IP(CTR_IP), .RD_LAT(RD_LAT)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    exp_t         exq[$];
    logic [W-1:0] rq[$];
    bit           post_rst = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
    endtask

    // ---------------- PE column model (stores + read pipeline) ----------------
    logic [W-1:0] km [0:(1<<A)-1];
    logic [W-1:0] nm [0:(1<<A)-1];
    logic [A:0]   ptr = '0;
    logic [W-1:0] pipe [0:RD_LAT-1];

    always @(posedge CLK) begin
        case (bus.controlSignal[1:0])
            OP_CLR:  ptr <= '0;
            OP_LOAD: begin
                km[ptr[A-1:0]] <= bus.kernelOut;
                nm[ptr[A-1:0]] <= bus.neuronOut;
                ptr <= ptr + 1'b1;
            end
            OP_COMP: ptr <= ptr + 1'b1;
            default: ;
        endcase
        // garbage outside compute reads so unsampled cycles are visible
        pipe[0] <= (bus.controlSignal[1:0] == OP_COMP) ?
                   W'(km[ptr[A-1:0]] * nm[ptr[A-1:0]]) : W'($urandom);
        for (int j = 1; j < RD_LAT; j++) pipe[j] <= pipe[j-1];
    end
    assign bus.colAdderOut = pipe[RD_LAT-1];

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] kk[$], input logic [W-1:0] nn[$]);
        longint acc = 0;
        bit     sat = 1'b0;
        logic [W-1:0] p;
        for (int i = 0; i < kk.size(); i++) begin
            p = W'(kk[i] * nn[i]);
`ifdef PE_SEQ_SAT_EN
            if (!sat) begin
                acc += longint'($signed(p));
                if (acc > (longint'(1) <<< (W-1)) - 1) begin
                    acc = (longint'(1) <<< (W-1)) - 1; sat = 1'b1;
                end else if (acc < -(longint'(1) <<< (W-1))) begin
                    acc = -(longint'(1) <<< (W-1)); sat = 1'b1;
                end
            end
`else
            acc += longint'(p);
`endif
        end
        return W'(acc);
    endfunction

    function automatic exp_t mk(input logic [1:0] op, input logic [W-1:0] k, input logic [W-1:0] n,
                                input logic jr, input logic lr, input logic rv, input logic z);
        exp_t e;
        e.op = op; e.k = k; e.n = n; e.jr = jr; e.lr = lr; e.rv = rv; e.z = z;
        return e;
    endfunction

    task automatic step(input exp_t e);
        exq.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic junk();
        bus.ld_kernel = W'($urandom);
        bus.ld_neuron = W'($urandom);
        bus.job_len   = (A+1)'($urandom);
    endtask

    // ---------------- stimulus: one job ----------------
    task automatic run_job(input int L, input int dmode, input int pat, input int hold, input bit abort3);
        logic [W-1:0] kk[$];
        logic [W-1:0] nn[$];
        int i, cyc, h;
        bit v;
        for (int j = 0; j < L; j++) begin
            case (dmode)
                D_FIX:   begin kk.push_back(W'(j + 1)); nn.push_back(W'(j + 5)); end
                D_SAT:   begin kk.push_back(W'(16'h7000)); nn.push_back(W'(1)); end
                default: begin kk.push_back(W'($urandom)); nn.push_back(W'($urandom)); end
            endcase
        end
        // IDLE: job accepted
        junk();
        bus.job_valid = 1'b1;
        bus.job_len   = (A+1)'(L);
        bus.ld_valid  = 1'($urandom);
        bus.res_ready = 1'($urandom);
        step(mk(OP_IDLE, '0, '0, 1'b1, 1'b0, 1'b0, post_rst));
        post_rst = 1'b0;
        bus.job_valid = 1'b0;
        rq.push_back(ref_result(kk, nn));
        // CLR: a beat offered here must not be taken
        junk(); bus.ld_valid = 1'b1;
        step(mk(OP_CLR, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
        if (L > 0) begin
            i = 0; cyc = 0;
            while (i < L) begin
                case (pat)
                    P_TOGGLE: v = (cyc % 2) == 0;
                    P_RAND:   v = ($urandom % 3) != 0;
                    default:  v = 1'b1;
                endcase
                junk();
                bus.ld_valid  = v;
                bus.res_ready = 1'($urandom);
                if (v) begin bus.ld_kernel = kk[i]; bus.ld_neuron = nn[i]; end
                step(mk(v ? OP_LOAD : OP_IDLE, v ? kk[i] : '0, v ? nn[i] : '0,
                        1'b0, 1'b1, 1'b0, 1'b0));
                if (v) i++;
                cyc++;
                if (abort3 && i == 3) begin
                    RST_N = 1'b0; bus.ld_valid = 1'b0;
                    step(mk(OP_IDLE, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0));
                    RST_N = 1'b1;
                    rq.delete();
                    post_rst = 1'b1;
                    return;
                end
            end
            // CLR2, then L compute cycles, then drain; extra beats stay offered
            junk(); bus.ld_valid = 1'b1;
            step(mk(OP_CLR, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
            for (int j = 0; j < L; j++) begin
                junk(); bus.ld_valid = 1'($urandom); bus.res_ready = 1'($urandom);
                step(mk(OP_COMP, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
            end
            for (int j = 0; j < RD_LAT; j++) begin
                junk(); bus.res_ready = 1'($urandom);
                step(mk(OP_IDLE, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0));
            end
        end
        // OUTPUT: held for h cycles, job requests ignored
        h = (hold < 0) ? int'($urandom_range(0, 4)) : hold;
        for (int j = 0; j < h; j++) begin
            junk();
            bus.res_ready = 1'b0;
            bus.job_valid = 1'($urandom);
            bus.ld_valid  = 1'($urandom);
            step(mk(OP_IDLE, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        bus.job_valid = 1'b0;
        bus.res_ready = 1'b1;
        step(mk(OP_IDLE, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0));
        bus.res_ready = 1'($urandom);
    endtask

    // ---------------- monitor / scoreboard ----------------
    exp_t           m_e;
    logic [AW-1:0]  m_act;
    logic [AW-1:0]  m_req;

    always @(negedge CLK) begin
        if (exq.size() > 0) begin
            m_e   = exq.pop_front();
            m_act = {bus.controlSignal, bus.kernelOut, bus.neuronOut, bus.colAdderIn,
                     bus.job_ready, bus.ld_ready, bus.res_valid};
            m_req = {CTR_IP'(m_e.op), m_e.k, m_e.n, {W{1'b0}}, m_e.jr, m_e.lr, m_e.rv};
            chk("cycle{ctl,k,n,addin,jr,lr,rv}", 64'(m_act), 64'(m_req));
            if (m_e.z) chk("reset_res_data", 64'(bus.res_data), 64'(0));
            if (bus.res_valid) begin
                if (rq.size() == 0) chk("res_unexpected", 64'(bus.res_valid), 64'(0));
                else begin
                    chk("res_data", 64'(bus.res_data), 64'(rq[0]));
                    if (bus.res_ready) void'(rq.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        bus.job_valid = 1'b0; bus.job_len = '0;
        bus.ld_valid = 1'b0; bus.ld_kernel = '0; bus.ld_neuron = '0;
        bus.res_ready = 1'b0;
        @(posedge CLK); #1;
        step(mk(OP_IDLE, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1));
        step(mk(OP_IDLE, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1));
        RST_N = 1'b1;
        post_rst = 1'b1;

        run_job(4,   D_FIX,  P_CONT,   2, 1'b0);   // 70
        run_job(3,   D_RAND, P_TOGGLE, -1, 1'b0);
        run_job(0,   D_RAND, P_CONT,   -1, 1'b0);  // result 0
        run_job(5,   D_RAND, P_CONT,   5, 1'b0);   // long output hold
        run_job(2,   D_SAT,  P_CONT,   -1, 1'b0);  // 0xE000 / 0x7FFF
        run_job(8,   D_RAND, P_CONT,   -1, 1'b1);  // reset after 3 beats
        run_job(2,   D_RAND, P_CONT,   -1, 1'b0);
        run_job(1 << A, D_RAND, P_RAND, -1, 1'b0); // full store
        for (int t = 0; t < 15; t++)
            run_job(int'($urandom_range(0, 20)), D_RAND, P_RAND, -1, 1'b0);
        bus.job_valid = 1'b0;
        step(mk(OP_IDLE, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
        @(negedge CLK);
        chk("expect_queue_drained", 64'(exq.size()), 64'(0));
        chk("result_queue_drained", 64'(rq.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
